// File: rtl/ntt_pkg.sv
// Shared types for the NTT memory-side control path.
// No logic, so no latency or backpressure of its own.
package ntt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ntt_addr_cnt.sv
// Base+offset address counter with last/terminal flags; address is combinational.
// No backpressure: advances on every inc, clr wins over inc.
module ntt_addr_cnt #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   limit,
    output logic [AW:0]   cnt,
    output logic [AW-1:0] addr,
    output logic          last,
    output logic          term
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + (AW+1)'(1);
        end
    end

    // Truncation to AW bits makes the address wrap at the top of the memory.
    assign addr = base + cnt[AW-1:0];
    assign last = (cnt == limit - (AW+1)'(1));
    assign term = (cnt == limit);

endmodule

// File: rtl/shiftreg.sv
// Fixed-depth delay line with synchronous clear; latency DEPTH cycles.
// No backpressure: a new value enters every cycle.
module shiftreg #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/ntt_batch_mem_ctrl.sv
// Streams a batch of polynomials from read BRAM into the SDF core and its results into write BRAM.
// Core input follows rd_en by RD_LAT cycles; writes follow core_finish with zero added latency; no backpressure.
module ntt_batch_mem_ctrl
    import ntt_pkg::*;
#(
    parameter int  LOGQ     = 64,
    parameter int  LOGN     = 10,
    parameter int  MAX_POLY = 4,
    parameter int  RD_LAT   = 2,
    localparam int PW       = (clog2(MAX_POLY) > 0) ? clog2(MAX_POLY) : 1,
    localparam int AW       = LOGN + clog2(MAX_POLY)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            intt,
    input  logic [PW-1:0]   num_poly_m1,
    input  logic [AW-1:0]   rd_base,
    input  logic [AW-1:0]   wr_base,
    input  logic [LOGQ-1:0] q,
    output logic            rd_en,
    output logic [AW-1:0]   rd_addr,
    input  logic [LOGQ-1:0] rd_data,
    output logic            wr_en,
    output logic [AW-1:0]   wr_addr,
    output logic [LOGQ-1:0] wr_data,
    output logic            core_start,
    output logic            core_intt,
    output logic [LOGQ-1:0] core_in,
    input  logic            core_finish,
    input  logic [LOGQ-1:0] core_out,
    output logic            busy,
    output logic            poly_done,
    output logic            done
);

    localparam logic [AW:0] POLY_MASK = (AW+1)'((1 << LOGN) - 1);
    localparam logic [AW:0] PRIME_END = (AW+1)'(RD_LAT - 1);

    state_t          state;
    logic            intt_r;
    logic [PW-1:0]   np_r;
    logic [AW-1:0]   rd_base_r;
    logic [AW-1:0]   wr_base_r;
    logic [AW:0]     total;
    logic            cnt_clr;
    logic [AW:0]     rd_cnt;
    logic [AW-1:0]   rd_addr_nxt;
    logic            rd_last;
    logic            rd_term;
    logic [AW:0]     wr_cnt;
    logic [AW-1:0]   wr_addr_nxt;
    logic            wr_last;
    logic            wr_term;
    logic            rd_vld;
    logic            core_hold;
    logic            poly_end;
    logic            unused_q;

    // The modulus is wired to the core beside this block; nothing here depends on it.
    assign unused_q = ^q;

    assign total    = ((AW+1)'(np_r) + (AW+1)'(1)) << LOGN;
    assign cnt_clr  = abort || (state == IDLE) || (state == DRAIN && wr_term);
    assign poly_end = ((wr_cnt & POLY_MASK) == POLY_MASK);

    ntt_addr_cnt #(.AW(AW)) u_rd_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (rd_en),
        .base  (rd_base_r),
        .limit (total),
        .cnt   (rd_cnt),
        .addr  (rd_addr_nxt),
        .last  (rd_last),
        .term  (rd_term)
    );

    ntt_addr_cnt #(.AW(AW)) u_wr_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (wr_en),
        .base  (wr_base_r),
        .limit (total),
        .cnt   (wr_cnt),
        .addr  (wr_addr_nxt),
        .last  (wr_last),
        .term  (wr_term)
    );

    // Marks the cycles in which rd_data carries a requested word.
    shiftreg #(.WIDTH(1), .DEPTH(RD_LAT)) u_vld_sr (
        .clk  (clk),
        .rst  (rst || abort),
        .din  (rd_en),
        .dout (rd_vld)
    );

    assign rd_en      = (state == PRIME || state == STREAM) && !rd_term;
    assign rd_addr    = rd_en ? rd_addr_nxt : '0;
    assign wr_en      = (state == STREAM || state == DRAIN) && core_finish && !wr_term;
    assign wr_addr    = wr_en ? wr_addr_nxt : '0;
    assign wr_data    = wr_en ? core_out : '0;
    assign core_in    = rd_data;
    assign core_start = (state != IDLE) && (rd_vld || core_hold);
    assign core_intt  = intt_r;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            intt_r    <= 1'b0;
            np_r      <= '0;
            rd_base_r <= '0;
            wr_base_r <= '0;
            core_hold <= 1'b0;
            poly_done <= 1'b0;
            done      <= 1'b0;
        end else begin
            poly_done <= wr_en && poly_end && !abort;
            done      <= wr_en && wr_last && !abort;

            // Keeps core_start up once the first word arrives, after rd_en has dropped.
            if (abort || state == IDLE) begin
                core_hold <= 1'b0;
            end else if (rd_vld) begin
                core_hold <= 1'b1;
            end

            if (abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            intt_r    <= intt;
                            np_r      <= num_poly_m1;
                            rd_base_r <= rd_base;
                            wr_base_r <= wr_base;
                            state     <= PRIME;
                        end
                    end
                    PRIME: begin
                        if (rd_cnt == PRIME_END) begin
                            state <= STREAM;
                        end
                    end
                    STREAM: begin
                        if (rd_en && rd_last) begin
                            state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (wr_term) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
